// File: rtl/id_control_pipe.sv
// -----------------------------------------------------------------------------
// id_control_pipe
// Registered instruction-decode control stage of the pipelined MIPS core.
// Decodes opcode/funct into the control word and registers it as the ID/EX
// control bundle. It also produces the combinational pipeline stall for
// load-use hazards and for the multi-cycle multiply/divide unit (MDU), and it
// squashes the ID stage on a branch/jump flush.
//
// Optional feature macro: CTRL_COP0_EN
//   defined   : opcode 0x10 (COP0) decodes to regWrite only
//   undefined : opcode 0x10 decodes as an unknown command
// -----------------------------------------------------------------------------
module id_control_pipe #(
    parameter int ALUOP_W     = 6,
    parameter int REG_W       = 5,
    parameter int MDU_LATENCY = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [31:0]        i_instr,
    input  logic               i_flush,
    output logic               o_stall,
    output logic               o_valid,
    output logic               o_regDst,
    output logic               o_jump,
    output logic               o_beq,
    output logic               o_bne,
    output logic               o_memToReg,
    output logic               o_memWrite,
    output logic               o_memRead,
    output logic               o_aluSrc_op2,
    output logic               o_regWrite,
    output logic               o_extOp,
    output logic [ALUOP_W-1:0] o_aluOp,
    output logic               o_unknown_command,
    output logic               o_mdu_start,
    output logic               o_mdu_busy
);

    // Opcodes understood by the control table
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
`ifdef CTRL_COP0_EN
    localparam logic [5:0] OP_COP0  = 6'h10;
`endif
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes relevant to the MDU
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;

    localparam logic [3:0] MDU_CNT_LOAD = 4'(MDU_LATENCY);

    // Control flags carried through the ID/EX register
    typedef struct packed {
        logic reg_dst;
        logic jump;
        logic beq;
        logic bne;
        logic mem_to_reg;
        logic mem_write;
        logic mem_read;
        logic alu_src_op2;
        logic reg_write;
        logic ext_op;
        logic unknown;
    } ctrl_t;

    typedef enum logic [0:0] {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    // Instruction fields of the word currently in ID
    logic [5:0]         opcode_s;
    logic [5:0]         funct_s;
    logic [REG_W-1:0]   id_rs_s;
    logic [REG_W-1:0]   id_rt_s;
    logic [ALUOP_W+5:0] opcode_ext_s;
    logic [ALUOP_W-1:0] aluop_s;

    assign opcode_s     = i_instr[31:26];
    assign funct_s      = i_instr[5:0];
    assign id_rs_s      = REG_W'(i_instr[25:21]);
    assign id_rt_s      = REG_W'(i_instr[20:16]);
    // Zero-extend the opcode, then keep the low ALUOP_W bits (extends or truncates)
    assign opcode_ext_s = {{ALUOP_W{1'b0}}, opcode_s};
    assign aluop_s      = opcode_ext_s[ALUOP_W-1:0];

    // ID/EX registers
    ctrl_t              ctrl_q,  ctrl_d;
    logic               valid_q, valid_d;
    logic [ALUOP_W-1:0] aluop_q, aluop_d;
    logic [REG_W-1:0]   rt_q,    rt_d;

    // MDU state
    mdu_state_t         mdu_state_q, mdu_state_d;
    logic [3:0]         cnt_q,       cnt_d;
    logic               mdu_start_q, mdu_start_d;

    // Decode helpers
    ctrl_t              dec_s;
    logic               is_rtype_s;
    logic               rt_is_src_s;
    logic               is_mdu_op_s;
    logic               is_mdu_read_s;
    logic               load_use_s;
    logic               mdu_stall_s;
    logic               stall_s;
    logic               accept_s;
    logic               mdu_launch_s;

    // Opcode decode into the control word
    always_comb begin
        dec_s = '0;
        case (opcode_s)
            OP_RTYPE: begin
                dec_s.reg_dst   = 1'b1;
                dec_s.reg_write = 1'b1;
            end
            OP_ADDI, OP_ADDIU: begin
                dec_s.reg_write   = 1'b1;
                dec_s.alu_src_op2 = 1'b1;
                dec_s.ext_op      = 1'b1;
            end
            OP_LUI, OP_ORI, OP_XORI, OP_ANDI: begin
                dec_s.reg_write   = 1'b1;
                dec_s.alu_src_op2 = 1'b1;
            end
            OP_LW: begin
                dec_s.reg_write   = 1'b1;
                dec_s.alu_src_op2 = 1'b1;
                dec_s.mem_to_reg  = 1'b1;
                dec_s.ext_op      = 1'b1;
                dec_s.mem_read    = 1'b1;
            end
            OP_SW: begin
                dec_s.alu_src_op2 = 1'b1;
                dec_s.mem_write   = 1'b1;
                dec_s.ext_op      = 1'b1;
            end
            OP_J:   dec_s.jump = 1'b1;
            OP_BEQ: dec_s.beq  = 1'b1;
            OP_BNE: dec_s.bne  = 1'b1;
`ifdef CTRL_COP0_EN
            OP_COP0: dec_s.reg_write = 1'b1;
`endif
            default: dec_s.unknown = 1'b1;
        endcase
    end

    // Source-register usage and MDU-related instruction classes
    always_comb begin
        is_rtype_s    = (opcode_s == OP_RTYPE);
        rt_is_src_s   = is_rtype_s || (opcode_s == OP_SW) ||
                        (opcode_s == OP_BEQ) || (opcode_s == OP_BNE);
        // MULT/MULTU/DIV/DIVU occupy funct 0x18..0x1B
        is_mdu_op_s   = i_valid && is_rtype_s && (funct_s[5:2] == 4'b0110);
        is_mdu_read_s = i_valid && is_rtype_s &&
                        ((funct_s == FN_MFHI) || (funct_s == FN_MFLO));
    end

    // Hazard detection and stall generation (no dependence on o_stall itself)
    always_comb begin
        load_use_s = valid_q && ctrl_q.mem_read && (rt_q != '0) && i_valid &&
                     ((rt_q == id_rs_s) || (rt_is_src_s && (rt_q == id_rt_s)));
        mdu_stall_s = (mdu_state_q == MDU_BUSY) && (is_mdu_read_s || is_mdu_op_s);
        stall_s     = (load_use_s || mdu_stall_s) && !i_flush;
        accept_s    = !i_flush && !stall_s;
        mdu_launch_s = accept_s && is_mdu_op_s && (mdu_state_q == MDU_IDLE);
    end

    // ID/EX next value: flush bubble, stall bubble, or the decoded word
    always_comb begin
        ctrl_d  = '0;
        valid_d = 1'b0;
        aluop_d = '0;
        rt_d    = '0;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (stall_s) begin
            valid_d = 1'b0;
        end else if (i_valid) begin
            ctrl_d  = dec_s;
            valid_d = 1'b1;
            aluop_d = aluop_s;
            rt_d    = id_rt_s;
        end else begin
            valid_d = 1'b0;
        end
    end

    // ID/EX control register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            aluop_q <= '0;
            rt_q    <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            aluop_q <= aluop_d;
            rt_q    <= rt_d;
        end
    end

    // MDU occupancy FSM: next state, counter and start pulse (flush never aborts BUSY)
    always_comb begin
        mdu_state_d = mdu_state_q;
        cnt_d       = cnt_q;
        mdu_start_d = 1'b0;
        case (mdu_state_q)
            MDU_IDLE: begin
                if (mdu_launch_s) begin
                    mdu_state_d = MDU_BUSY;
                    cnt_d       = MDU_CNT_LOAD;
                    mdu_start_d = 1'b1;
                end else begin
                    mdu_state_d = MDU_IDLE;
                    cnt_d       = 4'd0;
                end
            end
            MDU_BUSY: begin
                if (cnt_q <= 4'd1) begin
                    mdu_state_d = MDU_IDLE;
                    cnt_d       = 4'd0;
                end else begin
                    mdu_state_d = MDU_BUSY;
                    cnt_d       = cnt_q - 4'd1;
                end
            end
            default: begin
                mdu_state_d = MDU_IDLE;
                cnt_d       = 4'd0;
            end
        endcase
    end

    // MDU state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mdu_state_q <= MDU_IDLE;
            cnt_q       <= 4'd0;
            mdu_start_q <= 1'b0;
        end else begin
            mdu_state_q <= mdu_state_d;
            cnt_q       <= cnt_d;
            mdu_start_q <= mdu_start_d;
        end
    end

    assign o_stall           = stall_s;
    assign o_valid           = valid_q;
    assign o_regDst          = ctrl_q.reg_dst;
    assign o_jump            = ctrl_q.jump;
    assign o_beq             = ctrl_q.beq;
    assign o_bne             = ctrl_q.bne;
    assign o_memToReg        = ctrl_q.mem_to_reg;
    assign o_memWrite        = ctrl_q.mem_write;
    assign o_memRead         = ctrl_q.mem_read;
    assign o_aluSrc_op2      = ctrl_q.alu_src_op2;
    assign o_regWrite        = ctrl_q.reg_write;
    assign o_extOp           = ctrl_q.ext_op;
    assign o_aluOp           = aluop_q;
    assign o_unknown_command = ctrl_q.unknown;
    assign o_mdu_start       = mdu_start_q;
    assign o_mdu_busy        = (mdu_state_q == MDU_BUSY);

endmodule

// File: tb/tb_id_control_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_control_pipe
// Directed self-checking bench for id_control_pipe (default parameters).
// Inputs are driven 1 time unit after the rising edge; o_stall is sampled
// after the inputs settle and registered outputs after each rising edge.
// -----------------------------------------------------------------------------
module tb_id_control_pipe;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_instr;
    logic        i_flush;
    logic        o_stall;
    logic        o_valid;
    logic        o_regDst, o_jump, o_beq, o_bne, o_memToReg, o_memWrite;
    logic        o_memRead, o_aluSrc_op2, o_regWrite, o_extOp;
    logic [5:0]  o_aluOp;
    logic        o_unknown_command;
    logic        o_mdu_start;
    logic        o_mdu_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // {regDst,jump,beq,bne,memToReg,memWrite,memRead,aluSrc_op2,regWrite,extOp,unknown}
    logic [10:0] ctrl_vec_s;
    assign ctrl_vec_s = {o_regDst, o_jump, o_beq, o_bne, o_memToReg, o_memWrite,
                         o_memRead, o_aluSrc_op2, o_regWrite, o_extOp, o_unknown_command};

    id_control_pipe dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_valid           (i_valid),
        .i_instr           (i_instr),
        .i_flush           (i_flush),
        .o_stall           (o_stall),
        .o_valid           (o_valid),
        .o_regDst          (o_regDst),
        .o_jump            (o_jump),
        .o_beq             (o_beq),
        .o_bne             (o_bne),
        .o_memToReg        (o_memToReg),
        .o_memWrite        (o_memWrite),
        .o_memRead         (o_memRead),
        .o_aluSrc_op2      (o_aluSrc_op2),
        .o_regWrite        (o_regWrite),
        .o_extOp           (o_extOp),
        .o_aluOp           (o_aluOp),
        .o_unknown_command (o_unknown_command),
        .o_mdu_start       (o_mdu_start),
        .o_mdu_busy        (o_mdu_busy)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic fl);
        i_valid = v;
        i_instr = ins;
        i_flush = fl;
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_MULTU= 6'h19;
    localparam logic [5:0] FN_MFLO = 6'h12;

    logic [31:0] vec_instr [8];
    logic [10:0] vec_ctrl  [8];
    logic [31:0] ins_v;
    int          start_cnt;

    initial begin
        // Control table vectors (expected values derived by hand)
        vec_instr[0] = itype(6'h08, 5'd6, 5'd5, 16'h0004); vec_ctrl[0] = 11'h00E; // ADDI
        vec_instr[1] = itype(6'h0D, 5'd6, 5'd5, 16'h00FF); vec_ctrl[1] = 11'h00C; // ORI
        vec_instr[2] = itype(6'h2B, 5'd1, 5'd3, 16'h0008); vec_ctrl[2] = 11'h02A; // SW
        vec_instr[3] = {6'h02, 26'h0000100};               vec_ctrl[3] = 11'h200; // J
        vec_instr[4] = itype(6'h04, 5'd1, 5'd2, 16'h0003); vec_ctrl[4] = 11'h100; // BEQ
        vec_instr[5] = itype(6'h05, 5'd1, 5'd2, 16'h0003); vec_ctrl[5] = 11'h080; // BNE
        vec_instr[6] = itype(6'h3F, 5'd1, 5'd2, 16'h0000); vec_ctrl[6] = 11'h001; // unknown
        vec_instr[7] = itype(6'h0F, 5'd0, 5'd9, 16'h1234); vec_ctrl[7] = 11'h00C; // LUI

        rst = 1'b1;
        i_valid = 1'b0;
        i_instr = 32'd0;
        i_flush = 1'b0;
        #12;
        check("rst_valid",  32'(o_valid), 32'd0);
        check("rst_ctrl",   32'(ctrl_vec_s), 32'd0);
        check("rst_start",  32'(o_mdu_start), 32'd0);
        check("rst_busy",   32'(o_mdu_busy), 32'd0);
        rst = 1'b0;
        step();

        // ---- LW r2,0(r1) then ADD r3,r2,r4: one stall cycle ----
        drive(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0000), 1'b0);
        check("lw_nostall", 32'(o_stall), 32'd0);
        step();
        check("lw_ctrl",  32'(ctrl_vec_s), 32'h05E);
        check("lw_valid", 32'(o_valid), 32'd1);
        check("lw_aluop", 32'(o_aluOp), 32'h23);
        drive(1'b1, rtype(5'd2, 5'd4, 5'd3, FN_ADD), 1'b0);
        check("lu_stall", 32'(o_stall), 32'd1);
        step();
        check("lu_bubble_valid", 32'(o_valid), 32'd0);
        check("lu_bubble_ctrl",  32'(ctrl_vec_s), 32'd0);
        check("lu_stall_once",   32'(o_stall), 32'd0);
        step();
        check("add_ctrl",  32'(ctrl_vec_s), 32'h404);
        check("add_valid", 32'(o_valid), 32'd1);

        // ---- LW r0 then ADD r3,r0,r4: no hazard on r0 ----
        drive(1'b1, itype(6'h23, 5'd1, 5'd0, 16'h0000), 1'b0);
        step();
        drive(1'b1, rtype(5'd0, 5'd4, 5'd3, FN_ADD), 1'b0);
        check("lw_r0_nostall", 32'(o_stall), 32'd0);
        step();
        check("lw_r0_add_valid", 32'(o_valid), 32'd1);

        // ---- LW r2 then SW r2 as rt source: stall; ADDI with rt=r2 dest: none ----
        drive(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0000), 1'b0);
        step();
        drive(1'b1, itype(6'h2B, 5'd5, 5'd2, 16'h0000), 1'b0);
        check("lu_sw_rt_stall", 32'(o_stall), 32'd1);
        drive(1'b1, itype(6'h08, 5'd7, 5'd2, 16'h0005), 1'b0);
        check("lu_addi_rt_dest", 32'(o_stall), 32'd0);
        drive(1'b0, rtype(5'd2, 5'd4, 5'd3, FN_ADD), 1'b0);
        check("lu_id_invalid", 32'(o_stall), 32'd0);
        step();
        check("invalid_bubble", 32'(o_valid), 32'd0);
        check("invalid_ctrl",   32'(ctrl_vec_s), 32'd0);

        // ---- Control table sweep ----
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, vec_instr[k], 1'b0);
            step();
            ins_v = vec_instr[k];
            check($sformatf("tbl%0d_ctrl", k), 32'(ctrl_vec_s), 32'(vec_ctrl[k]));
            check($sformatf("tbl%0d_aluop", k), 32'(o_aluOp), 32'(ins_v[31:26]));
        end

        // ---- COP0 (opcode 0x10) ----
        drive(1'b1, itype(6'h10, 5'd0, 5'd3, 16'h6000), 1'b0);
        step();
`ifdef CTRL_COP0_EN
        check("cop0_regwrite", 32'(o_regWrite), 32'd1);
        check("cop0_unknown",  32'(o_unknown_command), 32'd0);
`else
        check("cop0_unknown",  32'(o_unknown_command), 32'd1);
        check("cop0_regwrite", 32'(o_regWrite), 32'd0);
`endif

        // ---- MULT then MFLO: 4 stall cycles, MFLO in EX 5 edges after MULT ----
        drive(1'b1, rtype(5'd1, 5'd2, 5'd0, FN_MULT), 1'b0);
        check("mult_nostall", 32'(o_stall), 32'd0);
        step();
        check("mult_start", 32'(o_mdu_start), 32'd1);
        check("mult_busy",  32'(o_mdu_busy), 32'd1);
        start_cnt = 1;
        drive(1'b1, rtype(5'd0, 5'd0, 5'd5, FN_MFLO), 1'b0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("mflo_stall%0d", c), 32'(o_stall), 32'd1);
            check($sformatf("mflo_busy%0d", c), 32'(o_mdu_busy), 32'd1);
            step();
            if (o_mdu_start) start_cnt++;
        end
        check("mflo_release", 32'(o_stall), 32'd0);
        check("mdu_idle",     32'(o_mdu_busy), 32'd0);
        check("mflo_bubble",  32'(o_valid), 32'd0);
        check("start_once",   32'(start_cnt), 32'd1);
        step();
        check("mflo_ex_valid", 32'(o_valid), 32'd1);
        check("mflo_ex_ctrl",  32'(ctrl_vec_s), 32'h404);

        // ---- MULT in ID during the last BUSY cycle is stalled, accepted next edge ----
        drive(1'b1, rtype(5'd1, 5'd2, 5'd0, FN_MULT), 1'b0);
        step();
        drive(1'b0, 32'd0, 1'b0);
        step();
        step();
        step();
        check("cnt1_busy", 32'(o_mdu_busy), 32'd1);
        drive(1'b1, rtype(5'd3, 5'd4, 5'd0, FN_MULTU), 1'b0);
        check("cnt1_mult_stall", 32'(o_stall), 32'd1);
        step();
        check("cnt1_next_nostall", 32'(o_stall), 32'd0);
        check("cnt1_next_idle",    32'(o_mdu_busy), 32'd0);
        step();
        check("mult2_start", 32'(o_mdu_start), 32'd1);
        drive(1'b0, 32'd0, 1'b0);
        step();
        check("mult2_start_pulse", 32'(o_mdu_start), 32'd0);
        check("mult2_busy_cnt3",   32'(o_mdu_busy), 32'd1);

        // ---- Asynchronous reset during BUSY (cnt=3), no clock edge ----
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy",  32'(o_mdu_busy), 32'd0);
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_ctrl",  32'(ctrl_vec_s), 32'd0);
        check("arst_start", 32'(o_mdu_start), 32'd0);
        #1;
        rst = 1'b0;
        step();

        // ---- Flush with a pending load-use hazard ----
        drive(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0000), 1'b0);
        step();
        drive(1'b1, rtype(5'd2, 5'd4, 5'd3, FN_ADD), 1'b1);
        check("flush_nostall", 32'(o_stall), 32'd0);
        step();
        check("flush_bubble",  32'(o_valid), 32'd0);
        check("flush_memread", 32'(o_memRead), 32'd0);
        drive(1'b1, rtype(5'd2, 5'd4, 5'd3, FN_ADD), 1'b0);
        check("post_flush_nostall", 32'(o_stall), 32'd0);

        // ---- Flush with a MULT in ID: no launch ----
        drive(1'b1, rtype(5'd1, 5'd2, 5'd0, FN_MULT), 1'b1);
        step();
        check("flush_mult_start", 32'(o_mdu_start), 32'd0);
        check("flush_mult_busy",  32'(o_mdu_busy), 32'd0);
        drive(1'b0, 32'd0, 1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_control_pipe.md
# id_control_pipe

Registered instruction-decode control stage for the pipelined MIPS core, sitting between the IF/ID register and the EX stage. Decodes opcode/funct into the full control word and registers it as the ID/EX control bundle. Generates the pipeline stall for load-use hazards and for the multi-cycle multiply/divide unit (MDU). Squashes on branch/jump flush.

## Interface
- `ALUOP_W`, default 6: width of `o_aluOp`; opcode is zero-extended or truncated to this width.
- `REG_W`, default 5: register index width.
- `MDU_LATENCY`, default 4: cycles a MULT/MULTU/DIV/DIVU occupies the MDU; legal range 1..15.

Ports:
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_valid` in 1: `i_instr` holds a real instruction (0 = bubble).
- `i_instr` in 32: instruction from IF/ID.
- `i_flush` in 1: taken branch/jump resolved; squash ID this cycle.
- `o_stall` out 1: hold PC and IF/ID this cycle (combinational).
- `o_valid` out 1: registered control word is a real instruction.
- `o_regDst`, `o_jump`, `o_beq`, `o_bne`, `o_memToReg`, `o_memWrite`, `o_memRead`, `o_aluSrc_op2`, `o_regWrite`, `o_extOp` out 1 each: registered controls.
- `o_aluOp` out `ALUOP_W`: registered opcode.
- `o_unknown_command` out 1: registered; the EX-stage instruction was undecodable.
- `o_mdu_start` out 1: registered one-cycle pulse; launch the MDU.
- `o_mdu_busy` out 1: MDU counter non-zero.

## Operation
- Decode matches the existing control table:
  - R-type: regDst, regWrite.
  - ADDI/ADDIU: regWrite, aluSrc_op2, extOp.
  - LUI/ORI/XORI/ANDI: regWrite, aluSrc_op2.
  - LW: regWrite, aluSrc_op2, memToReg, extOp, memRead.
  - SW: aluSrc_op2, memWrite, extOp.
  - J: jump. BEQ: beq. BNE: bne.
  - Any other opcode: unknown_command only.
- Every cycle, the ID/EX register loads one of three things, in priority order:
  1. Flush (`i_flush`): a bubble (all controls 0, `o_valid`=0). `o_stall` is forced to 0.
  2. Stall (`o_stall`): a bubble. IF/ID is held by the external logic.
  3. Otherwise: the decoded word, with `o_valid`=`i_valid`. When `i_valid`=0, all controls are 0.
- Load-use hazard: asserted when all of the following hold:
  - registered `o_valid` & `o_memRead`, and the registered rt ≠ 0;
  - `i_valid`;
  - the registered rt equals the ID rs, or the ID rt where rt is a source (R-type, SW, BEQ, BNE).
  - Result: exactly one stall cycle.
- MDU state machine with states IDLE and BUSY, and a 4-bit down-counter `cnt`:
  - IDLE → BUSY when an R-type funct 0x18–0x1B is accepted (not stalled, not flushed). `cnt`←`MDU_LATENCY`, `o_mdu_start` pulses with that word.
  - BUSY decrements `cnt` each cycle. At `cnt`=1 it goes → IDLE (`cnt`←0).
  - Flush does not abort BUSY.
- MDU stall: asserted while BUSY when ID holds MFHI (0x10), MFLO (0x12) or another MULT/DIV.
- `o_stall` = (load-use | MDU stall) & ~`i_flush`.
- `o_mdu_busy` = (state == BUSY).

## Timing
- Reset values: every control output, `o_valid`, `o_unknown_command` and `o_mdu_start` are 0. State is IDLE, `cnt`=0, `o_mdu_busy`=0.
- Reset asserted mid-MDU operation: returns to IDLE immediately, without waiting for a clock edge.
- Decode latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- `o_stall` is combinational from `i_instr`, `i_valid`, `i_flush` and registered state. There is no path from `o_stall` to itself.
- MULT accepted at edge N:
  - `o_mdu_busy` is high for cycles N+1..N+`MDU_LATENCY`.
  - A dependent MFLO is accepted at the first edge after `o_mdu_busy` falls.
- A MULT in ID on the same cycle as BUSY's last cycle (`cnt`=1) is stalled. It is accepted on the next edge.
- `i_flush` together with a hazard: flush wins, with no stall and no MDU launch.

## Configuration
- `CTRL_COP0_EN`, when defined: opcode 0x10 (COP0) decodes to regWrite only.
- When undefined: COP0 decodes as unknown (`o_unknown_command`=1, all other controls 0).

## Test plan
- Reset applied during BUSY (`cnt`=3) → all outputs 0, `o_mdu_busy`=0, with no clock edge needed.
- LW r2,0(r1) then ADD r3,r2,r4 → `o_stall`=1 for exactly 1 cycle. Bubble (`o_valid`=0) in EX, then ADD with regDst=1, regWrite=1.
- LW r0,0(r1) then ADD r3,r0,r4 → no stall.
- MULT (`MDU_LATENCY`=4) then MFLO → `o_mdu_start` pulses once, `o_stall`=1 for 4 cycles, MFLO reaches EX on the 5th cycle after MULT.
- `i_flush`=1 with LW-use hazard pending → `o_stall`=0, EX gets a bubble; next cycle `o_memRead`=0.
- Opcode 0x10 with `i_valid`=1 → `o_regWrite`=1 when `CTRL_COP0_EN` is defined. Without it, `o_unknown_command`=1 and `o_regWrite`=0.
